// File: rtl/my9262_pkg.sv
// MY9262 frame scheduler shared definitions.
// Latch codes, FSM state encoding and the default config command word.
package my9262_pkg;

    localparam logic [1:0] LAT_NONE   = 2'd0;
    localparam logic [1:0] LAT_DATA   = 2'd1;
    localparam logic [1:0] LAT_GLOBAL = 2'd2;
    localparam logic [1:0] LAT_CFG    = 2'd3;

    localparam logic [15:0] CFG_WORD_DEF = 16'h0EA0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_SEND,
        ST_CFG_WAIT,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_DATA_SEND,
        ST_DATA_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/my9262_word_seq.sv
// Nested chip/channel down-counters producing the frame-buffer address.
// Ports: clk_i, rst_i, load_i, step_i -> rd_addr_o, is_last_chip_o, is_last_word_o.
module my9262_word_seq
    import my9262_pkg::*;
#(
    parameter int N_CHIPS = 32,
    parameter int N_CH    = 16,
    parameter int ADDR_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              is_last_chip_o,
    output logic              is_last_word_o
);

    localparam int CW = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam int HW = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Wide enough to hold chip*N_CH + ch without overflow.
    localparam int AF = CW + HW;

    localparam logic [CW-1:0] CHIP_MAX = CW'(N_CHIPS - 1);
    localparam logic [HW-1:0] CH_MAX   = HW'(N_CH - 1);

    logic [CW-1:0] chip_q, chip_d;
    logic [HW-1:0] ch_q, ch_d;
    logic [AF-1:0] addr_full;

    always_comb begin
        chip_d = chip_q;
        ch_d   = ch_q;
        if (load_i) begin
            chip_d = CHIP_MAX;
            ch_d   = CH_MAX;
        end else if (step_i) begin
            if (chip_q == '0) begin
                chip_d = CHIP_MAX;
                ch_d   = (ch_q == '0) ? CH_MAX : ch_q - 1'b1;
            end else begin
                chip_d = chip_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chip_q <= '0;
            ch_q   <= '0;
        end else begin
            chip_q <= chip_d;
            ch_q   <= ch_d;
        end
    end

    assign addr_full      = AF'(chip_q) * AF'(N_CH) + AF'(ch_q);
    assign rd_addr_o      = ADDR_W'(addr_full);
    assign is_last_chip_o = (chip_q == '0);
    assign is_last_word_o = (chip_q == '0) && (ch_q == '0);

endmodule

// File: rtl/my9262_frame_sched.sv
// Frame scheduler: sequences config and grayscale words to the MY9262 serializer.
// Ports: start/cfg_update in, frame-buffer read port, serializer req/ack/done handshake.
module my9262_frame_sched
    import my9262_pkg::*;
#(
    parameter int          N_CHIPS  = 32,
    parameter int          N_CH     = 16,
    parameter logic [15:0] CFG_WORD = CFG_WORD_DEF,
    parameter int          ADDR_W   = 9
) (
    input  logic              CLK_200M,
    input  logic              RST,
    input  logic              start,
    input  logic              cfg_update,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              ser_req,
    output logic [15:0]       ser_data,
    output logic [1:0]        ser_lat,
    input  logic              ser_ack,
    input  logic              ser_done
);

    state_t      state_q, state_d;
    logic        cfg_pending_q, cfg_pending_d;
    logic [15:0] data_q, data_d;
    logic        seq_load, seq_step, cfg_clr;
    logic        last_chip, last_word;
    logic        in_cfg, in_data;

    // The chip counter doubles as the config word counter.
    my9262_word_seq #(
        .N_CHIPS(N_CHIPS),
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk_i         (CLK_200M),
        .rst_i         (RST),
        .load_i        (seq_load),
        .step_i        (seq_step),
        .rd_addr_o     (rd_addr),
        .is_last_chip_o(last_chip),
        .is_last_word_o(last_word)
    );

    always_comb begin
        state_d  = state_q;
        seq_load = 1'b0;
        seq_step = 1'b0;
        cfg_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seq_load = 1'b1;
                    state_d  = (cfg_pending_q || cfg_update) ? ST_CFG_SEND : ST_FETCH;
                end
            end
            ST_CFG_SEND: if (ser_ack) state_d = ST_CFG_WAIT;
            ST_CFG_WAIT: begin
                if (ser_done) begin
                    if (last_chip) begin
                        // Reload for the data phase instead of wrapping.
                        seq_load = 1'b1;
                        cfg_clr  = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        seq_step = 1'b1;
                        state_d  = ST_CFG_SEND;
                    end
                end
            end
            ST_FETCH:      state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_d = ST_DATA_SEND;
            ST_DATA_SEND:  if (ser_ack) state_d = ST_DATA_WAIT;
            ST_DATA_WAIT: begin
                if (ser_done) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        seq_step = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_pending_d = cfg_pending_q;
        if (cfg_update) begin
            cfg_pending_d = 1'b1;
        end else if (cfg_clr) begin
            cfg_pending_d = 1'b0;
        end
        data_d = (state_q == ST_FETCH_WAIT) ? rd_data : data_q;
    end

    always_ff @(posedge CLK_200M) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cfg_pending_q <= 1'b1;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            cfg_pending_q <= cfg_pending_d;
            data_q        <= data_d;
        end
    end

    assign in_cfg  = (state_q == ST_CFG_SEND) || (state_q == ST_CFG_WAIT);
    assign in_data = (state_q == ST_DATA_SEND) || (state_q == ST_DATA_WAIT);

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign frame_done = (state_q == ST_DONE);
    assign rd_en      = (state_q == ST_FETCH);
    assign ser_req    = (state_q == ST_CFG_SEND) || (state_q == ST_DATA_SEND);
    assign ser_data   = in_cfg ? CFG_WORD : data_q;

    // Counters hold through SEND/WAIT, so the tag is stable until ser_done.
    always_comb begin
        ser_lat = LAT_NONE;
        if (in_cfg) begin
            ser_lat = last_chip ? LAT_CFG : LAT_NONE;
        end else if (in_data) begin
            if (last_word) begin
                ser_lat = LAT_GLOBAL;
            end else if (last_chip) begin
                ser_lat = LAT_DATA;
            end
        end
    end

endmodule

// File: tb/tb_my9262_frame_sched.sv
// Self-checking bench for my9262_frame_sched with 4 chips x 2 channels.
// Table of expected words plus directed sequences for stall, reset and cfg cases.
module tb_my9262_frame_sched;

    localparam int NC = 4;
    localparam int NH = 2;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cfg_update = 1'b0;
    logic          busy, frame_done, rd_en, ser_req;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = 16'h0;
    logic [15:0]   ser_data;
    logic [1:0]    ser_lat;
    logic          ser_ack = 1'b0;
    logic          ser_done = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  lat;
    } vec_t;

    vec_t vecs [12];

    my9262_frame_sched #(
        .N_CHIPS (NC),
        .N_CH    (NH),
        .CFG_WORD(16'h0EA0),
        .ADDR_W  (AW)
    ) dut (
        .CLK_200M  (clk),
        .RST       (rst),
        .start     (start),
        .cfg_update(cfg_update),
        .busy      (busy),
        .frame_done(frame_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ser_req   (ser_req),
        .ser_data  (ser_data),
        .ser_lat   (ser_lat),
        .ser_ack   (ser_ack),
        .ser_done  (ser_done)
    );

    always #5 clk = ~clk;

    // Frame buffer: word at address a is 0xA000|a, one cycle after rd_en.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_en) rd_data <= 16'hA000 | 16'(rd_addr);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic serve(input int idx, input int delay, output bit ok);
        int t = 0;
        ok = 1'b1;
        while (!ser_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ser_req) begin
            chk($sformatf("word%0d_req_timeout", idx), 32'(ser_req), 32'd1);
            ok = 1'b0;
            return;
        end
        chk($sformatf("word%0d_data", idx), 32'(ser_data), 32'(vecs[idx].data));
        chk($sformatf("word%0d_lat", idx), 32'(ser_lat), 32'(vecs[idx].lat));
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk($sformatf("word%0d_stall_req", idx), 32'(ser_req), 32'd1);
            chk($sformatf("word%0d_stall_data", idx), 32'(ser_data), 32'(vecs[idx].data));
            chk($sformatf("word%0d_stall_lat", idx), 32'(ser_lat), 32'(vecs[idx].lat));
        end
        ser_ack = 1'b1;
        @(negedge clk);
        ser_ack = 1'b0;
        chk($sformatf("word%0d_req_drop", idx), 32'(ser_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("word%0d_wait_data", idx), 32'(ser_data), 32'(vecs[idx].data));
        chk($sformatf("word%0d_wait_lat", idx), 32'(ser_lat), 32'(vecs[idx].lat));
        ser_done = 1'b1;
        @(negedge clk);
        ser_done = 1'b0;
    endtask

    task automatic run_frame(input string nm, input bit cfg, input int delay_idx,
                             input int upd_idx, input int start_idx, input bit start_upd);
        int first;
        int fd0;
        bit ok;
        first = cfg ? 0 : 4;
        fd0   = fd_cnt;
        ok    = 1'b1;
        start      = 1'b1;
        cfg_update = start_upd;
        @(negedge clk);
        start      = 1'b0;
        cfg_update = 1'b0;
        chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
        chk({nm, "_first_req"}, 32'(ser_req), 32'(cfg));
        chk({nm, "_first_rd_en"}, 32'(rd_en), 32'(!cfg));
        for (int i = first; i < 12; i++) begin
            if (i == upd_idx) begin
                cfg_update = 1'b1;
                @(negedge clk);
                cfg_update = 1'b0;
            end
            if (i == start_idx) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            serve(i, (i == delay_idx) ? 5 : 0, ok);
            if (!ok) break;
        end
        chk({nm, "_frame_done"}, 32'(frame_done), 32'd1);
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({nm, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
        @(negedge clk);
        chk({nm, "_done_count"}, 32'(fd_cnt - fd0), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({nm, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({nm, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({nm, "_ser_req"}, 32'(ser_req), 32'd0);
        chk({nm, "_ser_data"}, 32'(ser_data), 32'd0);
        chk({nm, "_ser_lat"}, 32'(ser_lat), 32'd0);
    endtask

    initial begin
        int addrs [8];
        int t;
        addrs = '{7, 5, 3, 1, 6, 4, 2, 0};
        for (int i = 0; i < 4; i++) begin
            vecs[i].data = 16'h0EA0;
            vecs[i].lat  = (i == 3) ? 2'd3 : 2'd0;
        end
        for (int i = 0; i < 8; i++) begin
            vecs[4+i].data = 16'hA000 | 16'(addrs[i]);
            vecs[4+i].lat  = (i == 7) ? 2'd2 : ((i == 3) ? 2'd1 : 2'd0);
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("idle");

        run_frame("f1_cfg", 1'b1, -1, -1, -1, 1'b0);
        run_frame("f2_stall", 1'b0, 6, -1, -1, 1'b0);
        run_frame("f3_upd_mid", 1'b0, -1, 7, -1, 1'b0);
        run_frame("f4_cfg_busy_start", 1'b1, -1, -1, 9, 1'b0);
        run_frame("f5_start_upd", 1'b1, -1, -1, -1, 1'b1);

        // Reset while the first data word sits in DATA_WAIT.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_seq_rd_en", 32'(rd_en), 32'd1);
        t = 0;
        while (!ser_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_seq_req", 32'(ser_req), 32'd1);
        ser_ack = 1'b1;
        @(negedge clk);
        ser_ack = 1'b0;
        chk("rst_seq_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_req", 32'(ser_req), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        run_frame("f6_after_rst", 1'b1, -1, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
